// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings, FSM states and widths for shift_seq
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 6;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one combinational stage of the iterative shift, at most STEP positions
module shift_step
    import shift_pkg::*;
#(
    parameter int STEP = 8,
    localparam int KW = $clog2(STEP + 1)
) (
    input  logic [DATA_W-1:0] val,
    input  logic [KW-1:0]     k,
    input  logic [1:0]        op,
    input  logic              sign,
    output logic [DATA_W-1:0] res
);

    logic [DATA_W-1:0] fill_mask;

    always_comb begin
        // top k bits set: the positions vacated by a right shift
        fill_mask = ~({DATA_W{1'b1}} >> k);
        res       = val;
        case (op)
            OP_SRL:  res = val >> k;
            OP_SRA:  res = (val >> k) | (sign ? fill_mask : '0);
            OP_SLL:  res = val << k;
            default: res = val;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - multi-cycle shift sequencer with request/response handshakes
module shift_seq
    import shift_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DATA_W-1:0]  req_op1,
    input  logic [SHAMT_W-1:0] req_shamt,
    input  logic [1:0]         req_op,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DATA_W-1:0]  resp_res,
    output logic               resp_err,
    output logic               busy
);

    localparam int KW = $clog2(STEP + 1);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         op_q, op_d;
    logic               err_q, err_d;
    logic               sign_q, sign_d;

    logic [SHAMT_W-1:0] eff;
    logic [KW-1:0]      k;
    logic [DATA_W-1:0]  step_res;
    logic               accept;

    assign req_ready  = (state_q == IDLE) && rst_n;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == DONE);
    assign resp_res   = (state_q == DONE) ? work_q : '0;
    assign resp_err   = (state_q == DONE) ? err_q : 1'b0;
    assign busy       = (state_q != IDLE);

    // amounts past 32 behave exactly like 32, so the counter never needs more
    assign eff = (req_shamt > SHAMT_W'(32)) ? SHAMT_W'(32) : req_shamt;

    always_comb begin
        if (rem_q > SHAMT_W'(STEP)) k = KW'(STEP);
        else                        k = rem_q[KW-1:0];
    end

    shift_step #(.STEP(STEP)) u_step (
        .val  (work_q),
        .k    (k),
        .op   (op_q),
        .sign (sign_q),
        .res  (step_res)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        op_d    = op_q;
        err_d   = err_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = req_op;
                    sign_d = req_op1[DATA_W-1];
                    rem_d  = eff;
                    if (req_op == OP_ILL) begin
                        work_d  = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        work_d  = req_op1;
                        err_d   = 1'b0;
                        state_d = (eff == '0) ? DONE : SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = step_res;
                rem_d  = rem_q - SHAMT_W'(k);
                if (rem_d == '0) state_d = DONE;
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            op_q    <= OP_SRL;
            err_q   <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            err_q   <= err_d;
            sign_q  <= sign_d;
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - self-checking bench for shift_seq against a behavioural model
module tb_shift_seq;
    import shift_pkg::*;

    localparam int STEP = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_op1;
    logic [5:0]  req_shamt;
    logic [1:0]  req_op;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_res;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_seq #(.STEP(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_shamt  (req_shamt),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_res   (resp_res),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [31:0] a, input int sh, input logic [1:0] op);
        int eff;
        eff = (sh > 32) ? 32 : sh;
        case (op)
            2'b00:   return (eff >= 32) ? 32'd0 : (a >> eff);
            2'b01:   return 32'($signed(a) >>> ((eff > 31) ? 31 : eff));
            2'b10:   return (eff >= 32) ? 32'd0 : (a << eff);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input int sh, input logic [1:0] op);
        int eff;
        if (op == 2'b11) return 1;
        eff = (sh > 32) ? 32 : sh;
        return 1 + (eff + STEP - 1) / STEP;
    endfunction

    task automatic run(input logic [31:0] a, input int sh, input logic [1:0] op,
                       input int hold, input string tag);
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_lat;
        int          lat;
        exp_res = model_res(a, sh, op);
        exp_err = (op == 2'b11);
        exp_lat = model_lat(sh, op);
        req_op1    = a;
        req_shamt  = 6'(sh);
        req_op     = op;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op1   = $urandom;
        req_shamt = 6'($urandom);
        req_op    = 2'($urandom);
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".res"}, resp_res, exp_res);
        check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        check({tag, ".busy"}, 32'(busy), 32'd1);
        req_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".hold_res"}, resp_res, exp_res);
            check({tag, ".hold_err"}, 32'(resp_err), 32'(exp_err));
            check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, ".post_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ".post_busy"}, 32'(busy), 32'd0);
        check({tag, ".post_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op1    = '0;
        req_shamt  = '0;
        req_op     = 2'b00;
        resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_res", resp_res, 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        check("rst.rem", 32'(dut.rem_q), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst.release_ready", 32'(req_ready), 32'd1);

        run(32'hF000_000F, 13, OP_SRL, 0, "srl13");
        run(32'h8000_0010, 40, OP_SRA, 0, "sra40");
        run(32'h8000_0010, 4,  OP_SRA, 0, "sra4");
        run(32'h0000_0001, 31, OP_SLL, 0, "sll31");
        run(32'h0000_0001, 0,  OP_SLL, 0, "sll0");
        run(32'hDEAD_BEEF, 7,  OP_ILL, 0, "ill");
        run(32'h1234_5678, 8,  OP_SRL, 0, "after_ill");
        run(32'h7FFF_FFFF, 63, OP_SRA, 0, "sra63_pos");
        run(32'hFFFF_FFFF, 32, OP_SLL, 0, "sll32");
        run(32'hA5A5_A5A5, 16, OP_SRL, 10, "backpressure");

        req_op1   = 32'hFFFF_FFFF;
        req_shamt = 6'd32;
        req_op    = OP_SRL;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.resp_valid", 32'(resp_valid), 32'd0);
        check("abort.resp_res", resp_res, 32'd0);
        check("abort.resp_err", 32'(resp_err), 32'd0);
        check("abort.req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1;
        end
        resp_ready = 1'b0;
        check("abort.no_resp", 32'(seen), 32'd0);
        check("abort.ready_after", 32'(req_ready), 32'd1);

        for (int i = 0; i < 40; i++) begin
            run($urandom, $urandom_range(0, 63), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
